// File: rtl/lif_neuron_array.sv
// Multi-channel leaky integrate-and-fire neuron array with shared threshold and refractory period.
// Optional per-channel spike counters are built when LIF_SPIKE_COUNT_EN is defined.
module lif_neuron_array #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned REF_W = 3,
  parameter int unsigned SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    step,
  input  logic [N_CH*WIDTH-1:0]   current,
  input  logic [WIDTH-1:0]        threshold,
  input  logic [2:0]              leak_shift,
  input  logic [REF_W-1:0]        refrac_len,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        state_out,
  output logic [N_CH-1:0]         spike,
  output logic [7:0]              spike_cnt
);

  logic [WIDTH-1:0] pot_q  [N_CH];
  logic [WIDTH-1:0] pot_d  [N_CH];
  logic [REF_W-1:0] ref_q  [N_CH];
  logic [REF_W-1:0] ref_d  [N_CH];
  logic [WIDTH-1:0] leak_v [N_CH];
  logic [WIDTH:0]   sum_v  [N_CH];
  logic [WIDTH-1:0] new_v  [N_CH];
  logic [N_CH-1:0]  spike_d;
  logic [SEL_W-1:0] sel_ch;

  // Out-of-range selects fall back to channel 0.
  always_comb begin
    sel_ch = '0;
    if (32'(sel) < N_CH) begin
      sel_ch = sel;
    end
  end

  always_comb begin
    spike_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      pot_d[i]  = pot_q[i];
      ref_d[i]  = ref_q[i];
      leak_v[i] = (leak_shift == 3'd0) ? '0 : (pot_q[i] >> leak_shift);
      // Extra bit catches overflow so the sum can saturate instead of wrapping.
      sum_v[i]  = {1'b0, pot_q[i] - leak_v[i]} + {1'b0, current[i*WIDTH +: WIDTH]};
      new_v[i]  = sum_v[i][WIDTH] ? '1 : sum_v[i][WIDTH-1:0];
      if (step) begin
        if (ref_q[i] != '0) begin
          ref_d[i] = ref_q[i] - REF_W'(1);
          pot_d[i] = '0;
        end else if (new_v[i] >= threshold) begin
          spike_d[i] = 1'b1;
          pot_d[i]   = '0;
          ref_d[i]   = refrac_len;
        end else begin
          pot_d[i] = new_v[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        pot_q[i] <= '0;
        ref_q[i] <= '0;
      end
      spike     <= '0;
      state_out <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        pot_q[i] <= pot_d[i];
        ref_q[i] <= ref_d[i];
      end
      spike     <= spike_d;
      state_out <= pot_q[sel_ch];
    end
  end

`ifdef LIF_SPIKE_COUNT_EN
  logic [7:0] cnt_q [N_CH];
  logic [7:0] cnt_d [N_CH];

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (spike_d[i] && (cnt_q[i] != 8'hff)) begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
      spike_cnt <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      spike_cnt <= cnt_q[sel_ch];
    end
  end
`else
  assign spike_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_lif_neuron_array.sv
// Scoreboard bench for lif_neuron_array: the driver queues hand-computed results per step,
// a negedge monitor pops and compares as each step's outputs appear.
module tb_lif_neuron_array;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           step;
  logic [N*W-1:0] current;
  logic [W-1:0]   threshold;
  logic [2:0]     leak_shift;
  logic [2:0]     refrac_len;
  logic [1:0]     sel;
  logic [W-1:0]   state_out;
  logic [N-1:0]   spike;
  logic [7:0]     spike_cnt;

  lif_neuron_array #(
    .N_CH  (N),
    .WIDTH (W),
    .REF_W (3),
    .SEL_W (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .step       (step),
    .current    (current),
    .threshold  (threshold),
    .leak_shift (leak_shift),
    .refrac_len (refrac_len),
    .sel        (sel),
    .state_out  (state_out),
    .spike      (spike),
    .spike_cnt  (spike_cnt)
  );

  always #5 clk = ~clk;

  logic [N-1:0] exp_spk [$];
  logic [7:0]   exp_pot [$];
  logic [7:0]   exp_cnt [$];
  int           ecnt [N];
  string        tag = "reset";
  logic         end_req = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // Step seen at edge k: spike checked after edge k, state_out/spike_cnt after edge k+1.
  logic s1 = 1'b0, s2 = 1'b0, rc1 = 1'b0, ec1 = 1'b0;
  always @(posedge clk) begin
    s1  <= step && !rst;
    s2  <= s1;
    rc1 <= rst;
    ec1 <= end_req;
  end

  always @(negedge clk) begin
    logic [N-1:0] es;
    logic [7:0]   ep, ec;
    if (rc1) begin
      vectors++;
      if (state_out !== 8'd0 || spike !== 4'd0 || spike_cnt !== 8'd0) begin
        miscompares++;
        $display("FAIL reset: state_out=%0d spike=%b spike_cnt=%0d, required 0 0000 0",
                 state_out, spike, spike_cnt);
      end
    end
    if (s1) begin
      vectors++;
      if (exp_spk.size() == 0) begin
        miscompares++;
        $display("FAIL %s spike: got %b with no expected entry", tag, spike);
      end else begin
        es = exp_spk.pop_front();
        if (spike !== es) begin
          miscompares++;
          $display("FAIL %s spike: got %b, required %b", tag, spike, es);
        end
      end
    end
    if (s2) begin
      vectors++;
      if (exp_pot.size() == 0) begin
        miscompares++;
        $display("FAIL %s state: got %0d with no expected entry", tag, state_out);
      end else begin
        ep = exp_pot.pop_front();
        ec = exp_cnt.pop_front();
        if (state_out !== ep || spike_cnt !== ec) begin
          miscompares++;
          $display("FAIL %s state: state_out=%0d spike_cnt=%0d, required %0d %0d",
                   tag, state_out, spike_cnt, ep, ec);
        end
      end
    end
    if (ec1) begin
      vectors++;
      if (exp_spk.size() != 0 || exp_pot.size() != 0) begin
        miscompares++;
        $display("FAIL drain: %0d spike and %0d state entries left, required 0 0",
                 exp_spk.size(), exp_pot.size());
      end
    end
  end

  task automatic do_step(input logic [N*W-1:0] cur, input logic [N-1:0] sp, input logic [7:0] pt);
    @(negedge clk);
    step    = 1'b1;
    current = cur;
    exp_spk.push_back(sp);
    for (int i = 0; i < N; i++) begin
      if (sp[i] && ecnt[i] < 255) ecnt[i]++;
    end
    exp_pot.push_back(pt);
`ifdef LIF_SPIKE_COUNT_EN
    exp_cnt.push_back(8'(ecnt[sel]));
`else
    exp_cnt.push_back(8'd0);
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      step    = 1'b0;
      current = '0;
    end
  endtask

  task automatic cfg(input logic [1:0] s, input logic [2:0] ls, input logic [7:0] th,
                     input logic [2:0] rl, input string t);
    sel        = s;
    leak_shift = ls;
    threshold  = th;
    refrac_len = rl;
    tag        = t;
  endtask

  initial begin
    for (int i = 0; i < N; i++) ecnt[i] = 0;
    rst     = 1'b1;
    step    = 1'b1;
    current = 32'h05050505;
    cfg(2'd0, 3'd0, 8'd10, 3'd0, "reset");
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    step = 1'b0;
    idle(2);

    cfg(2'd0, 3'd0, 8'd100, 3'd0, "integrate");
    do_step(32'h0000001E, 4'b0000, 8'd30);
    do_step(32'h0000001E, 4'b0000, 8'd60);
    do_step(32'h0000001E, 4'b0000, 8'd90);
    do_step(32'h0000001E, 4'b0001, 8'd0);
    idle(2);

    cfg(2'd1, 3'd1, 8'd255, 3'd0, "leak");
    do_step(32'h00000A00, 4'b0000, 8'd10);
    do_step(32'h00000A00, 4'b0000, 8'd15);
    do_step(32'h00000A00, 4'b0000, 8'd18);
    do_step(32'h00000A00, 4'b0000, 8'd19);
    do_step(32'h00000A00, 4'b0000, 8'd20);
    do_step(32'h00000A00, 4'b0000, 8'd20);
    do_step(32'h00000A00, 4'b0000, 8'd20);
    idle(2);

    cfg(2'd2, 3'd0, 8'd255, 3'd0, "saturate");
    do_step(32'h00C80000, 4'b0000, 8'd200);
    do_step(32'h00C80000, 4'b0100, 8'd0);
    idle(2);

    cfg(2'd3, 3'd0, 8'd50, 3'd2, "refractory");
    do_step(32'h3C000000, 4'b1000, 8'd0);
    do_step(32'h3C000000, 4'b0000, 8'd0);
    idle(3);
    do_step(32'h3C000000, 4'b0000, 8'd0);
    do_step(32'h3C000000, 4'b1000, 8'd0);
    idle(2);

    // ch3 is refractory again here; reset must release it at once.
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < N; i++) ecnt[i] = 0;
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    cfg(2'd3, 3'd0, 8'd60, 3'd0, "reset_refrac");
    do_step(32'h3C000000, 4'b1000, 8'd0);
    idle(2);

    cfg(2'd3, 3'd0, 8'd61, 3'd0, "below_thresh");
    do_step(32'h3C000000, 4'b0000, 8'd60);
    do_step(32'h3C000000, 4'b1000, 8'd0);
    idle(2);

    cfg(2'd0, 3'd0, 8'd0, 3'd0, "thresh0_count");
    for (int k = 0; k < 300; k++) begin
      do_step(32'h00000000, 4'b1111, 8'd0);
    end
    idle(3);

    @(negedge clk);
    end_req = 1'b1;
    @(negedge clk);
    end_req = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lif_neuron_array.md
# lif_neuron_array

Parametrised multi-channel leaky integrate-and-fire neuron array, successor to the single-neuron LIF core. It holds `N_CH` independent membrane potentials of `WIDTH` bits and updates them on each `step` strobe with configurable leak, shared threshold and a refractory period. It emits a per-channel spike vector and exposes one channel's potential through a select mux. It sits behind the top-level pin wrapper, which drives `uo_out` from `state_out` and the spike pins from `spike`.

## Interface
- `N_CH`, 4: number of neuron channels (≥1).
- `WIDTH`, 8: membrane potential, current and threshold width.
- `REF_W`, 3: refractory counter width.
- `SEL_W`, `$clog2(N_CH)` (min 1): width of `sel`.

- `clk` in 1: sole clock, all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `step` in 1: update strobe; all channels integrate on a cycle where it is high.
- `current` in `N_CH*WIDTH`: packed unsigned input currents; channel i is `current[i*WIDTH +: WIDTH]`.
- `threshold` in `WIDTH`: shared firing threshold, unsigned.
- `leak_shift` in 3: leak = potential >> `leak_shift`; 0 disables leak.
- `refrac_len` in `REF_W`: steps a channel is held after a spike; 0 = none.
- `sel` in `SEL_W`: channel shown on `state_out`/`spike_cnt`; out-of-range selects channel 0.
- `state_out` out `WIDTH`: registered potential of channel `sel`.
- `spike` out `N_CH`: registered one-cycle spike pulses, one bit per channel.
- `spike_cnt` out 8: spike count of channel `sel` (see Configuration).

## Operation
- Per channel registers: `pot[WIDTH]`, `ref_cnt[REF_W]`, optional `cnt[8]`.
- Cycle with `step`=0: all state held; `spike` = 0.
- Cycle with `step`=1, per channel i independently:
  - If `ref_cnt` ≠ 0: `ref_cnt` decrements by 1, `pot` ← 0, no spike, `current` ignored.
  - Else: `leak` = (`leak_shift`==0) ? 0 : `pot` >> `leak_shift`; `sum` = (`pot` − `leak`) + `current_i`, computed in `WIDTH+1` bits; `new` = min(`sum`, 2^WIDTH−1).
  - If `new` ≥ `threshold`: `spike[i]` ← 1, `pot` ← 0, `ref_cnt` ← `refrac_len`.
  - Else: `pot` ← `new`, `spike[i]` ← 0.
- `threshold` = 0: every non-refractory step fires.
- Saturated value equal to `threshold` fires (≥ comparison on saturated value).
- `state_out` is a registered mux of `pot[sel]`; reflects the post-update value.
- Inputs `threshold`, `leak_shift`, `refrac_len` are sampled on the step cycle; changes between steps take effect on the next step.

## Timing
- Reset values: all `pot` = 0, `ref_cnt` = 0, counters = 0, `state_out` = 0, `spike` = 0, `spike_cnt` = 0.
- `rst` has priority over `step` in the same cycle; reset mid-refractory clears it immediately.
- Latency: `step` sampled at edge k → updated `pot`, `spike` visible after edge k; `state_out` reflects it after edge k+1 (one extra register stage on the mux).
- `sel` change → `state_out`/`spike_cnt` update one cycle later.
- `spike` bits are high exactly one cycle per firing step; back-to-back steps may produce spikes on consecutive cycles when `refrac_len`=0.
- No backpressure: `step` may be high every cycle.

## Configuration
- `LIF_SPIKE_COUNT_EN` defined: each channel has an 8-bit counter incremented on each of its spikes, saturating at 255, cleared by `rst`; `spike_cnt` = count of channel `sel`, registered like `state_out`.
- Undefined: counters not built; `spike_cnt` tied to 0.

## Test plan
- Reset: hold `rst`=1 two cycles with nonzero `current`, `step`=1 → `state_out`=0, `spike`=0, `spike_cnt`=0 after release.
- Pure integration: `leak_shift`=0, `threshold`=100, ch0 `current`=30, `step`=1 continuously → ch0 pot 30, 60, 90, then spike[0]=1 on 4th step with pot 0; other channels (current 0) never fire.
- Leak: `leak_shift`=1, `threshold`=255, ch1 `current`=10 → pot 10, 15, 18, 19, 19+, settling at 20 and holding; no spike.
- Saturation: `leak_shift`=0, `threshold`=255, ch2 `current`=200 → pot 200, then sum 400 saturates to 255 → spike[2]=1, pot 0.
- Refractory: `refrac_len`=2, `threshold`=50, ch3 `current`=60 → spike on step 1, no spike and pot 0 on steps 2–3, spike on step 4; `step` gaps do not consume refractory.
- Counter (macro defined): ch0 fires 300 times, `sel`=0 → `spike_cnt`=255; with macro undefined `spike_cnt`=0 throughout.
